// File: rtl/axi_llc_data_way_arb.sv
// LLC data way arbiter: shares one data-way SRAM controller between NumReq cache units.
// Beat requests are granted round-robin. The way stays locked to one unit while an offered
// beat waits for acceptance (HOLD) and for the rest of a multi-beat burst (BURST).
// Read responses are routed back to the issuing unit by their id tag.
module axi_llc_data_way_arb #(
  parameter int unsigned NumReq    = 4,
  parameter int unsigned AddrWidth = 10,
  parameter int unsigned DataWidth = 64,
  parameter int unsigned IdWidth   = (NumReq > 1) ? $clog2(NumReq) : 1
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  // Cache-unit request side
  input  logic [NumReq-1:0]               req_valid_i,
  output logic [NumReq-1:0]               req_ready_o,
  input  logic [NumReq*AddrWidth-1:0]     req_addr_i,
  input  logic [NumReq-1:0]               req_we_i,
  input  logic [NumReq*DataWidth-1:0]     req_data_i,
  input  logic [NumReq*DataWidth/8-1:0]   req_strb_i,
  input  logic [NumReq-1:0]               req_last_i,
  // Data way request side
  output logic                            way_valid_o,
  input  logic                            way_ready_i,
  output logic [IdWidth-1:0]              way_id_o,
  output logic [AddrWidth-1:0]            way_addr_o,
  output logic                            way_we_o,
  output logic [DataWidth-1:0]            way_data_o,
  output logic [DataWidth/8-1:0]          way_strb_o,
  // Data way response side
  input  logic                            way_rsp_valid_i,
  output logic                            way_rsp_ready_o,
  input  logic [IdWidth-1:0]              way_rsp_id_i,
  input  logic [DataWidth-1:0]            way_rsp_data_i,
  // Cache-unit response side
  output logic [NumReq-1:0]               rsp_valid_o,
  input  logic [NumReq-1:0]               rsp_ready_i,
  output logic [DataWidth-1:0]            rsp_data_o,
  // Status
  output logic                            lock_o,
  output logic [IdWidth-1:0]              grant_id_o,
  output logic                            err_o
);

  localparam int unsigned StrbWidth = DataWidth / 8;

  typedef logic [IdWidth-1:0] id_t;

  typedef enum logic [1:0] {
    StIdle,
    StHold,
    StBurst
  } state_e;

  // Successor of a unit id, wrapping NumReq-1 back to 0 (NumReq need not be a power of two).
  function automatic id_t inc_id(input id_t id);
    if (32'(id) == NumReq - 1) begin
      return '0;
    end
    return id + id_t'(1);
  endfunction

  state_e state_q, state_d;
  id_t    gnt_q, gnt_d;
  id_t    rr_ptr_q, rr_ptr_d;
  logic   err_q, err_d;

  logic   arb_found;
  id_t    arb_id;
  id_t    sel_id;
  logic   sel_valid;
  logic   sel_last;
  logic   handshake;
  logic   rsp_in_range;

  // Round-robin pick: first valid unit at or above rr_ptr_q, else the lowest valid unit.
  always_comb begin
    arb_found = 1'b0;
    arb_id    = rr_ptr_q;
    for (int unsigned k = 0; k < NumReq; k++) begin
      if (!arb_found && req_valid_i[k] && (32'(k) >= 32'(rr_ptr_q))) begin
        arb_found = 1'b1;
        arb_id    = id_t'(k);
      end
    end
    for (int unsigned k = 0; k < NumReq; k++) begin
      if (!arb_found && req_valid_i[k]) begin
        arb_found = 1'b1;
        arb_id    = id_t'(k);
      end
    end
  end

  // Request field mux: fresh arbitration in IDLE, the locked unit in HOLD/BURST.
  always_comb begin
    sel_id     = (state_q == StIdle) ? arb_id : gnt_q;
    sel_valid  = 1'b0;
    sel_last   = 1'b0;
    way_addr_o = '0;
    way_we_o   = 1'b0;
    way_data_o = '0;
    way_strb_o = '0;
    for (int unsigned k = 0; k < NumReq; k++) begin
      if (id_t'(k) == sel_id) begin
        sel_valid  = req_valid_i[k];
        sel_last   = req_last_i[k];
        way_addr_o = req_addr_i[k*AddrWidth +: AddrWidth];
        way_we_o   = req_we_i[k];
        way_data_o = req_data_i[k*DataWidth +: DataWidth];
        way_strb_o = req_strb_i[k*StrbWidth +: StrbWidth];
      end
    end
  end

  // Handshake outputs; way_valid_o never depends on way_ready_i.
  always_comb begin
    way_valid_o = (state_q == StIdle) ? arb_found : sel_valid;
    way_id_o    = sel_id;
    grant_id_o  = sel_id;
    handshake   = way_valid_o && way_ready_i;
    req_ready_o = '0;
    for (int unsigned k = 0; k < NumReq; k++) begin
      req_ready_o[k] = handshake && (id_t'(k) == sel_id);
    end
  end

  assign lock_o = (state_q != StIdle);
  assign err_o  = err_q;

  // Next-state logic: lock on stalled offers and open bursts, advance pointer on last beat.
  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    rr_ptr_d = rr_ptr_q;
    case (state_q)
      StIdle: begin
        if (arb_found) begin
          if (handshake) begin
            if (sel_last) begin
              rr_ptr_d = inc_id(arb_id);
            end else begin
              gnt_d   = arb_id;
              state_d = StBurst;
            end
          end else begin
            gnt_d   = arb_id;
            state_d = StHold;
          end
        end
      end
      StHold, StBurst: begin
        if (handshake) begin
          if (sel_last) begin
            rr_ptr_d = inc_id(gnt_q);
            state_d  = StIdle;
          end else begin
            state_d  = StBurst;
          end
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Response demux: tags outside the unit range are sunk and flagged.
  always_comb begin
    rsp_valid_o     = '0;
    way_rsp_ready_o = 1'b1;
    rsp_in_range    = 1'b0;
    for (int unsigned k = 0; k < NumReq; k++) begin
      if (id_t'(k) == way_rsp_id_i) begin
        rsp_in_range    = 1'b1;
        rsp_valid_o[k]  = way_rsp_valid_i;
        way_rsp_ready_o = rsp_ready_i[k];
      end
    end
    rsp_data_o = way_rsp_data_i;
    err_d      = err_q | (way_rsp_valid_i & ~rsp_in_range);
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      gnt_q    <= '0;
      rr_ptr_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      rr_ptr_q <= rr_ptr_d;
      err_q    <= err_d;
    end
  end

`ifndef SYNTHESIS
  // A unit holding an offer must keep it up until accepted.
  hold_valid_kept: assert property (@(posedge clk_i) disable iff (rst_i)
    (state_q == StHold) |-> way_valid_o);

  // An offered, unaccepted beat keeps its fields until accepted.
  offer_stable: assert property (@(posedge clk_i) disable iff (rst_i)
    (way_valid_o && !way_ready_i) |=> ($stable(way_id_o) && $stable(way_addr_o)
                                       && $stable(way_data_o) && $stable(way_we_o)));
`endif

endmodule

// File: tb/tb_axi_llc_data_way_arb.sv
// Directed bench for axi_llc_data_way_arb: a table of per-cycle vectors for a 4-unit
// instance plus hand-written sequences for a 3-unit instance and the response path.
module tb_axi_llc_data_way_arb;

  logic clk;
  logic rst;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 4-unit instance
  logic [3:0]   a_req_valid, a_req_ready, a_req_we, a_req_last;
  logic [39:0]  a_req_addr;
  logic [255:0] a_req_data;
  logic [31:0]  a_req_strb;
  logic         a_way_valid, a_way_ready, a_way_we;
  logic [1:0]   a_way_id, a_grant_id, a_way_rsp_id;
  logic [9:0]   a_way_addr;
  logic [63:0]  a_way_data, a_way_rsp_data, a_rsp_data;
  logic [7:0]   a_way_strb;
  logic         a_way_rsp_valid, a_way_rsp_ready, a_lock, a_err;
  logic [3:0]   a_rsp_valid, a_rsp_ready;

  // 3-unit instance
  logic [2:0]   b_req_valid, b_req_ready, b_req_we, b_req_last;
  logic [23:0]  b_req_addr;
  logic [47:0]  b_req_data;
  logic [5:0]   b_req_strb;
  logic         b_way_valid, b_way_ready, b_way_we;
  logic [1:0]   b_way_id, b_grant_id, b_way_rsp_id;
  logic [7:0]   b_way_addr;
  logic [15:0]  b_way_data, b_way_rsp_data, b_rsp_data;
  logic [1:0]   b_way_strb;
  logic         b_way_rsp_valid, b_way_rsp_ready, b_lock, b_err;
  logic [2:0]   b_rsp_valid, b_rsp_ready;

  axi_llc_data_way_arb #(
    .NumReq   (4),
    .AddrWidth(10),
    .DataWidth(64)
  ) u_dut_a (
    .clk_i          (clk),
    .rst_i          (rst),
    .req_valid_i    (a_req_valid),
    .req_ready_o    (a_req_ready),
    .req_addr_i     (a_req_addr),
    .req_we_i       (a_req_we),
    .req_data_i     (a_req_data),
    .req_strb_i     (a_req_strb),
    .req_last_i     (a_req_last),
    .way_valid_o    (a_way_valid),
    .way_ready_i    (a_way_ready),
    .way_id_o       (a_way_id),
    .way_addr_o     (a_way_addr),
    .way_we_o       (a_way_we),
    .way_data_o     (a_way_data),
    .way_strb_o     (a_way_strb),
    .way_rsp_valid_i(a_way_rsp_valid),
    .way_rsp_ready_o(a_way_rsp_ready),
    .way_rsp_id_i   (a_way_rsp_id),
    .way_rsp_data_i (a_way_rsp_data),
    .rsp_valid_o    (a_rsp_valid),
    .rsp_ready_i    (a_rsp_ready),
    .rsp_data_o     (a_rsp_data),
    .lock_o         (a_lock),
    .grant_id_o     (a_grant_id),
    .err_o          (a_err)
  );

  axi_llc_data_way_arb #(
    .NumReq   (3),
    .AddrWidth(8),
    .DataWidth(16)
  ) u_dut_b (
    .clk_i          (clk),
    .rst_i          (rst),
    .req_valid_i    (b_req_valid),
    .req_ready_o    (b_req_ready),
    .req_addr_i     (b_req_addr),
    .req_we_i       (b_req_we),
    .req_data_i     (b_req_data),
    .req_strb_i     (b_req_strb),
    .req_last_i     (b_req_last),
    .way_valid_o    (b_way_valid),
    .way_ready_i    (b_way_ready),
    .way_id_o       (b_way_id),
    .way_addr_o     (b_way_addr),
    .way_we_o       (b_way_we),
    .way_data_o     (b_way_data),
    .way_strb_o     (b_way_strb),
    .way_rsp_valid_i(b_way_rsp_valid),
    .way_rsp_ready_o(b_way_rsp_ready),
    .way_rsp_id_i   (b_way_rsp_id),
    .way_rsp_data_i (b_way_rsp_data),
    .rsp_valid_o    (b_rsp_valid),
    .rsp_ready_i    (b_rsp_ready),
    .rsp_data_o     (b_rsp_data),
    .lock_o         (b_lock),
    .grant_id_o     (b_grant_id),
    .err_o          (b_err)
  );

  typedef struct packed {
    logic       rst;
    logic [3:0] valid;
    logic [3:0] last;
    logic       rdy;
    logic       e_valid;
    logic [1:0] e_id;
    logic [3:0] e_ready;
    logic       e_lock;
  } vec_t;

  localparam int NumVec = 21;
  vec_t vecs [NumVec];

  int checks;
  int failures;

  function automatic vec_t mk(input logic r, input logic [3:0] v, input logic [3:0] l,
                              input logic rdy, input logic ev, input logic [1:0] eid,
                              input logic [3:0] erdy, input logic el);
    vec_t x;
    x.rst = r; x.valid = v; x.last = l; x.rdy = rdy;
    x.e_valid = ev; x.e_id = eid; x.e_ready = erdy; x.e_lock = el;
    return x;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;

    // Unit k offers addr 0x100+k, data {CAFE0000, k}, strobe bit k, we = k[0].
    for (int k = 0; k < 4; k++) begin
      a_req_addr[k*10 +: 10] = 10'(10'h100 + k);
      a_req_data[k*64 +: 64] = {32'hCAFE0000, 32'(k)};
      a_req_strb[k*8 +: 8]   = 8'(8'h1 << k);
      a_req_we[k]            = 1'(k % 2);
    end
    for (int k = 0; k < 3; k++) begin
      b_req_addr[k*8 +: 8]   = 8'(8'h40 + k);
      b_req_data[k*16 +: 16] = 16'(16'hB000 + k);
      b_req_strb[k*2 +: 2]   = 2'b11;
      b_req_we[k]            = 1'b0;
    end
    rst = 1'b1;
    a_req_valid = '0; a_req_last = '0; a_way_ready = 1'b0;
    a_way_rsp_valid = 1'b0; a_way_rsp_id = '0; a_way_rsp_data = '0; a_rsp_ready = '0;
    b_req_valid = '0; b_req_last = '0; b_way_ready = 1'b0;
    b_way_rsp_valid = 1'b0; b_way_rsp_id = '0; b_way_rsp_data = '0; b_rsp_ready = '0;

    //               rst  valid    last     rdy   ev    id     ready    lock
    vecs[0]  = mk(1'b1, 4'b0000, 4'b1111, 1'b1, 1'b0, 2'd0, 4'b0000, 1'b0); // reset
    vecs[1]  = mk(1'b0, 4'b0101, 4'b1111, 1'b1, 1'b1, 2'd0, 4'b0001, 1'b0); // rr 0,2
    vecs[2]  = mk(1'b0, 4'b0101, 4'b1111, 1'b1, 1'b1, 2'd2, 4'b0100, 1'b0);
    vecs[3]  = mk(1'b0, 4'b0101, 4'b1111, 1'b1, 1'b1, 2'd0, 4'b0001, 1'b0);
    vecs[4]  = mk(1'b0, 4'b0101, 4'b1111, 1'b1, 1'b1, 2'd2, 4'b0100, 1'b0);
    vecs[5]  = mk(1'b1, 4'b0000, 4'b1111, 1'b1, 1'b0, 2'd0, 4'b0000, 1'b0); // reset
    vecs[6]  = mk(1'b0, 4'b1111, 4'b1111, 1'b0, 1'b1, 2'd0, 4'b0000, 1'b0); // stall
    vecs[7]  = mk(1'b0, 4'b1111, 4'b1111, 1'b0, 1'b1, 2'd0, 4'b0000, 1'b1); // HOLD
    vecs[8]  = mk(1'b0, 4'b1111, 4'b1111, 1'b0, 1'b1, 2'd0, 4'b0000, 1'b1);
    vecs[9]  = mk(1'b0, 4'b1111, 4'b1111, 1'b1, 1'b1, 2'd0, 4'b0001, 1'b1); // accept
    vecs[10] = mk(1'b0, 4'b1111, 4'b1111, 1'b1, 1'b1, 2'd1, 4'b0010, 1'b0); // next = 1
    vecs[11] = mk(1'b0, 4'b1010, 4'b1111, 1'b1, 1'b1, 2'd3, 4'b1000, 1'b0);
    vecs[12] = mk(1'b0, 4'b1010, 4'b1000, 1'b1, 1'b1, 2'd1, 4'b0010, 1'b0); // burst b1
    vecs[13] = mk(1'b0, 4'b1010, 4'b1000, 1'b1, 1'b1, 2'd1, 4'b0010, 1'b1); // b2
    vecs[14] = mk(1'b0, 4'b1000, 4'b1000, 1'b1, 1'b0, 2'd1, 4'b0000, 1'b1); // bubble
    vecs[15] = mk(1'b0, 4'b1010, 4'b1000, 1'b1, 1'b1, 2'd1, 4'b0010, 1'b1); // b3
    vecs[16] = mk(1'b0, 4'b1010, 4'b1010, 1'b1, 1'b1, 2'd1, 4'b0010, 1'b1); // b4 last
    vecs[17] = mk(1'b0, 4'b1000, 4'b1000, 1'b1, 1'b1, 2'd3, 4'b1000, 1'b0); // unit 3
    vecs[18] = mk(1'b0, 4'b0001, 4'b0000, 1'b1, 1'b1, 2'd0, 4'b0001, 1'b0); // burst b1
    vecs[19] = mk(1'b1, 4'b0101, 4'b0000, 1'b1, 1'b1, 2'd0, 4'b0001, 1'b1); // rst on b2
    vecs[20] = mk(1'b0, 4'b0100, 4'b0100, 1'b1, 1'b1, 2'd2, 4'b0100, 1'b0); // unit 2 now

    repeat (2) @(negedge clk);

    for (int i = 0; i < NumVec; i++) begin
      @(negedge clk);
      rst         = vecs[i].rst;
      a_req_valid = vecs[i].valid;
      a_req_last  = vecs[i].last;
      a_way_ready = vecs[i].rdy;
      #1;
      check($sformatf("v%0d way_valid", i), 64'(a_way_valid), 64'(vecs[i].e_valid));
      check($sformatf("v%0d req_ready", i), 64'(a_req_ready), 64'(vecs[i].e_ready));
      check($sformatf("v%0d lock", i), 64'(a_lock), 64'(vecs[i].e_lock));
      if (vecs[i].e_valid) begin
        check($sformatf("v%0d way_id", i), 64'(a_way_id), 64'(vecs[i].e_id));
        check($sformatf("v%0d grant_id", i), 64'(a_grant_id), 64'(vecs[i].e_id));
        check($sformatf("v%0d way_addr", i), 64'(a_way_addr), 64'(10'h100 + vecs[i].e_id));
        check($sformatf("v%0d way_data", i), a_way_data, {32'hCAFE0000, 30'd0, vecs[i].e_id});
        check($sformatf("v%0d way_strb", i), 64'(a_way_strb), 64'(8'h1 << vecs[i].e_id));
        check($sformatf("v%0d way_we", i), 64'(a_way_we), 64'(vecs[i].e_id[0]));
      end
      if (vecs[i].rst) check($sformatf("v%0d err", i), 64'(a_err), 64'd0);
    end

    // 3-unit wrap: all units valid, single beats, grant order 0,1,2,0.
    @(negedge clk);
    a_req_valid = '0;
    a_way_ready = 1'b0;
    b_req_valid = 3'b111;
    b_req_last  = 3'b111;
    b_way_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      logic [1:0] exp_id;
      exp_id = 2'(i % 3);
      if (i > 0) @(negedge clk);
      #1;
      check($sformatf("wrap%0d way_id", i), 64'(b_way_id), 64'(exp_id));
      check($sformatf("wrap%0d req_ready", i), 64'(b_req_ready), 64'(3'b001 << exp_id));
      check($sformatf("wrap%0d way_addr", i), 64'(b_way_addr), 64'(8'h40 + exp_id));
      check($sformatf("wrap%0d lock", i), 64'(b_lock), 64'd0);
    end

    // Response to unit 2 stalled for two cycles; other units' readies must not matter.
    @(negedge clk);
    b_req_valid     = '0;
    b_way_ready     = 1'b0;
    a_way_rsp_valid = 1'b1;
    a_way_rsp_id    = 2'd2;
    a_way_rsp_data  = 64'h1234_5678_9ABC_DEF0;
    a_rsp_ready     = 4'b1011;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      if (i == 2) a_rsp_ready = 4'b0100;
      #1;
      check($sformatf("rsp%0d valid", i), 64'(a_rsp_valid), 64'(4'b0100));
      check($sformatf("rsp%0d ready", i), 64'(a_way_rsp_ready), (i == 2) ? 64'd1 : 64'd0);
      check($sformatf("rsp%0d data", i), a_rsp_data, 64'h1234_5678_9ABC_DEF0);
    end
    @(negedge clk);
    a_way_rsp_valid = 1'b0;
    #1;
    check("rsp idle valid", 64'(a_rsp_valid), 64'd0);
    check("rsp a err", 64'(a_err), 64'd0);

    // 3-unit: in-range tag 1, then out-of-range tag 3 dropped and flagged until reset.
    b_way_rsp_valid = 1'b1;
    b_way_rsp_id    = 2'd1;
    b_way_rsp_data  = 16'hBEEF;
    b_rsp_ready     = 3'b010;
    #1;
    check("b id1 valid", 64'(b_rsp_valid), 64'(3'b010));
    check("b id1 ready", 64'(b_way_rsp_ready), 64'd1);
    check("b id1 data", 64'(b_rsp_data), 64'h0000_0000_0000_BEEF);
    @(negedge clk);
    b_way_rsp_id = 2'd3;
    b_rsp_ready  = 3'b000;
    #1;
    check("b id3 valid", 64'(b_rsp_valid), 64'd0);
    check("b id3 ready", 64'(b_way_rsp_ready), 64'd1);
    check("b id3 err before edge", 64'(b_err), 64'd0);
    @(negedge clk);
    b_way_rsp_valid = 1'b0;
    #1;
    check("b err set", 64'(b_err), 64'd1);
    @(negedge clk);
    #1;
    check("b err sticky", 64'(b_err), 64'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("b err cleared", 64'(b_err), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
